// File: rtl/write_back_arbiter_pkg.sv
// write_back_arbiter_pkg: shared datapath types and write-back defaults
package write_back_arbiter_pkg;
  typedef logic [31:0] DataPath;
  typedef logic [4:0] RegNumPath;
  typedef struct packed {
    logic valid;
    RegNumPath num;
    DataPath data;
  } WbEntry;
  localparam int WB_FIFO_DEPTH = 4;
  localparam int WB_STARVE_LIMIT = 3;
endpackage

// File: rtl/write_back_arbiter_wb_fifo.sv
// wb_fifo: long-latency result buffer with parallel squash by register number
module wb_fifo
  import write_back_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  WbEntry                       push_entry,
  input  logic                         pop,
  input  logic                         squash,
  input  RegNumPath                    squash_num,
  output WbEntry                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  WbEntry mem [DEPTH];
  logic [PW-1:0] hp, tp;
  assign head = mem[hp];
  always_ff @(posedge clk) begin
    if (rst) begin
      hp <= '0;
      tp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash && mem[i].num == squash_num) mem[i].valid <= 1'b0;
      // a concurrent push is older than the squashing ALU write
      if (push) begin
        mem[tp] <= push_entry;
        mem[tp].valid <= push_entry.valid && !(squash && push_entry.num == squash_num);
        tp <= tp + 1'b1;
      end
      if (pop) hp <= hp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/write_back_arbiter.sv
// write_back_arbiter: sole register-file write port driver merging ALU and buffered long-latency results
module write_back_arbiter
  import write_back_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       aluWrEnable,
  input  RegNumPath                  aluWrNum,
  input  DataPath                    aluWrData,
  output logic                       aluStall,
  input  logic                       memValid,
  output logic                       memReady,
  input  RegNumPath                  memWrNum,
  input  DataPath                    memWrData,
  output logic                       wrEnable,
  output RegNumPath                  wrNum,
  output DataPath                    wrData,
  output logic [$clog2(DEPTH+1)-1:0] fifoCount
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  WbEntry head, push_entry;
  logic [SW-1:0] starve;
  logic nonempty, head_valid, alu_grant, mem_grant, pop, push;
  assign push_entry = '{valid: 1'b1, num: memWrNum, data: memWrData};
  always_comb begin
    nonempty = fifoCount != '0;
    head_valid = nonempty && head.valid;
    aluStall = starve == SW'(STARVE_LIMIT) && head_valid;
    alu_grant = aluWrEnable && !aluStall;
    mem_grant = !alu_grant && head_valid;
    pop = !alu_grant && nonempty;
    memReady = fifoCount < ($clog2(DEPTH+1))'(DEPTH);
    push = memValid && memReady;
  end
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk,
    .rst,
    .push,
    .push_entry,
    .pop,
    .squash(alu_grant),
    .squash_num(aluWrNum),
    .head,
    .count(fifoCount)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      wrEnable <= 1'b0;
      wrNum <= '0;
      wrData <= '0;
      starve <= '0;
    end else begin
      wrEnable <= alu_grant || mem_grant;
      wrNum <= alu_grant ? aluWrNum : mem_grant ? head.num : wrNum;
      wrData <= alu_grant ? aluWrData : mem_grant ? head.data : wrData;
      starve <= (pop || !head_valid) ? '0 :
                (alu_grant && starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
    end
  end
endmodule

// File: tb/tb_write_back_arbiter.sv
// tb_write_back_arbiter: directed and random stimulus against a queue-based reference model
module tb_write_back_arbiter;
  logic clk = 0, rst = 1;
  logic alu_en = 0, mem_valid = 0;
  logic [4:0] alu_num = 0, mem_num = 0;
  logic [31:0] alu_data = 0, mem_data = 0;
  logic alu_stall, mem_ready, wr_en;
  logic [4:0] wr_num;
  logic [31:0] wr_data;
  logic [2:0] fifo_count;
  int n_cmp = 0, n_err = 0;

  write_back_arbiter dut (
    .clk(clk), .rst(rst),
    .aluWrEnable(alu_en), .aluWrNum(alu_num), .aluWrData(alu_data), .aluStall(alu_stall),
    .memValid(mem_valid), .memReady(mem_ready), .memWrNum(mem_num), .memWrData(mem_data),
    .wrEnable(wr_en), .wrNum(wr_num), .wrData(wr_data), .fifoCount(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic v; logic [4:0] n; logic [31:0] d;} ent_t;
  ent_t q[$];
  int m_starve = 0;
  logic m_we = 0;
  logic [4:0] m_num = 0;
  logic [31:0] m_data = 0;
  logic last_stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_head_valid();
    return q.size() > 0 && q[0].v;
  endfunction

  // one clock: check registered outputs, drive, check combinational outputs, advance model
  task automatic cyc(input logic r, input logic ae, input logic [4:0] an, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mn, input logic [31:0] md);
    logic stall, ag, mg, pp, ready;
    ent_t e;
    @(negedge clk);
    check("wrEnable", wr_en, m_we);
    check("wrNum", wr_num, m_num);
    check("wrData", wr_data, m_data);
    check("fifoCount", fifo_count, q.size());
    rst = r; alu_en = ae; alu_num = an; alu_data = ad;
    mem_valid = mv; mem_num = mn; mem_data = md;
    #1;
    stall = m_starve == 3 && m_head_valid();
    ready = q.size() < 4;
    check("aluStall", alu_stall, stall);
    check("memReady", mem_ready, ready);
    last_stall = stall;
    if (r) begin
      q.delete(); m_starve = 0; m_we = 0; m_num = 0; m_data = 0;
    end else begin
      ag = ae && !stall;
      mg = !ag && m_head_valid();
      pp = !ag && q.size() > 0;
      m_we = ag || mg;
      if (ag) begin m_num = an; m_data = ad; end
      else if (mg) begin m_num = q[0].n; m_data = q[0].d; end
      if (pp || !m_head_valid()) m_starve = 0;
      else if (ag && m_starve < 3) m_starve++;
      if (pp) void'(q.pop_front());
      if (mv && ready) begin e.v = 1; e.n = mn; e.d = md; q.push_back(e); end
      if (ag) foreach (q[i]) if (q[i].n == an) q[i].v = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    logic ae;
    logic [4:0] an;
    logic [31:0] ad;
    rst = 1;
    repeat (2) @(posedge clk);
    idle(1);
    // ALU only
    cyc(0, 1, 1, 14, 0, 0, 0);
    idle(2);
    // single mem result
    cyc(0, 0, 0, 0, 1, 5, 10);
    idle(3);
    // backpressure: ALU busy while mem results pile up, fifth held until a pop
    k = 0;
    for (int i = 0; i < 10; i++) begin
      logic rdy = q.size() < 4;
      cyc(0, 1, 5'(1 + i % 4), 32'(100 + i), k < 5, 5'(20 + k), 32'(200 + k));
      if (rdy && k < 5) k++;
    end
    idle(6);
    // starvation: head waits behind a continuous ALU stream to reg 2
    cyc(0, 1, 2, 50, 1, 6, 9);
    for (int i = 0; i < 7; i++) cyc(0, 1, 2, 32'(51 + i), 0, 0, 0);
    idle(2);
    // squash: later ALU write to reg 3 kills the buffered and the concurrent mem result
    cyc(0, 1, 1, 7, 1, 3, 12);
    cyc(0, 1, 3, 99, 1, 3, 55);
    idle(4);
    // reset mid-operation with three entries pending
    for (int i = 0; i < 3; i++) cyc(0, 1, 5'(8 + i), 32'(300 + i), 1, 5'(12 + i), 32'(400 + i));
    cyc(1, 1, 9, 1, 1, 9, 2);
    idle(4);
    // random traffic with small register range to provoke squashes
    ae = 0; an = 0; ad = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(last_stall && ae)) begin
        ae = $urandom_range(0, 99) < 70;
        an = 5'($urandom_range(0, 7));
        ad = $urandom;
      end
      cyc($urandom_range(0, 199) == 0, ae, an, ad,
          $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom);
    end
    idle(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
